// File: rtl/c2h_rr_arbiter_if.sv
// AXI-Stream C2H bundle: N lanes of tvalid/tdata/tlast/tuser with per-lane tready.
// The arbiter uses N=NUM_PORTS on the source side and N=1 on the QDMA side.
interface c2h_rr_arbiter_if #(
   parameter int N      = 1,
   parameter int DATA_W = 512,
   parameter int SIZE_W = 16,
   parameter int QID_W  = 11
);
   logic [N-1:0]        tvalid;
   logic [N*DATA_W-1:0] tdata;
   logic [N-1:0]        tlast;
   logic [N*SIZE_W-1:0] tuser_size;
   logic [N*QID_W-1:0]  tuser_qid;
   logic [N-1:0]        tready;

   modport master (
      output tvalid, tdata, tlast, tuser_size, tuser_qid,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tlast, tuser_size, tuser_qid,
      output tready
   );
endinterface

// File: rtl/c2h_rr_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS C2H streams onto one QDMA C2H stream.
// A granted port owns the output until its tlast beat handshakes; one IDLE bubble per packet.
module c2h_rr_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 512,
   parameter int SIZE_W    = 16,
   parameter int QID_W     = 11,
   parameter int CNT_W     = 32
) (
   input  logic                         axis_aclk,
   input  logic                         axis_areset,
   c2h_rr_arbiter_if.slave              s_axis,
   c2h_rr_arbiter_if.master             m_axis_c2h,
   output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
   output logic                         busy,
   output logic [CNT_W-1:0]             pkt_count
);
   localparam int IDX_W = $clog2(NUM_PORTS);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] grant;
   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] winner;
   logic             winner_found;
   logic             pkt_end;

   assign grant_idx = grant;

   // Search starts one past the previous owner and wraps, so every requester is reached within N-1 packets.
   always_comb begin
      int cand;
      cand         = 0;
      winner       = '0;
      winner_found = 1'b0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         cand = int'(last_grant) + k;
         if (cand >= NUM_PORTS) begin
            cand = cand - NUM_PORTS;
         end
         if (!winner_found && s_axis.tvalid[cand]) begin
            winner       = IDX_W'(cand);
            winner_found = 1'b1;
         end
      end
   end

   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      int g;
      g                     = int'(grant);
      state_nxt             = state;
      pkt_end               = 1'b0;
      m_axis_c2h.tvalid     = '0;
      m_axis_c2h.tdata      = '0;
      m_axis_c2h.tlast      = '0;
      m_axis_c2h.tuser_size = '0;
      m_axis_c2h.tuser_qid  = '0;
      s_axis.tready         = '0;
      case (state)
         IDLE: begin
            if (winner_found) begin
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            m_axis_c2h.tvalid     = s_axis.tvalid[g];
            m_axis_c2h.tdata      = s_axis.tdata[g*DATA_W +: DATA_W];
            m_axis_c2h.tlast      = s_axis.tlast[g];
            m_axis_c2h.tuser_size = s_axis.tuser_size[g*SIZE_W +: SIZE_W];
            m_axis_c2h.tuser_qid  = s_axis.tuser_qid[g*QID_W +: QID_W];
            s_axis.tready[g]      = m_axis_c2h.tready[0];
            pkt_end = s_axis.tvalid[g] & m_axis_c2h.tready[0] & s_axis.tlast[g];
            if (pkt_end) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // After reset last_grant points at the top port so port 0 is first in line.
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         grant      <= '0;
         last_grant <= IDX_W'(NUM_PORTS - 1);
         busy       <= 1'b0;
         pkt_count  <= '0;
      end else begin
         if (state == IDLE && winner_found) begin
            grant <= winner;
            busy  <= 1'b1;
         end
         if (pkt_end) begin
            last_grant <= grant;
            busy       <= 1'b0;
            pkt_count  <= pkt_count + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_c2h_rr_arbiter.sv
// Directed bench for c2h_rr_arbiter: a round-robin vector table plus hand-written multi-cycle sequences.
// Built with CNT_W=4 so the packet counter wrap is reachable in a few dozen cycles.
module tb_c2h_rr_arbiter;
   localparam int NP     = 4;
   localparam int DATA_W = 512;
   localparam int SIZE_W = 16;
   localparam int QID_W  = 11;
   localparam int CNT_W  = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [1:0]       grant_idx;
   logic             busy;
   logic [CNT_W-1:0] pkt_count;
   int               compared = 0;
   int               failed   = 0;

   c2h_rr_arbiter_if #(.N(NP), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .QID_W(QID_W)) s_if ();
   c2h_rr_arbiter_if #(.N(1),  .DATA_W(DATA_W), .SIZE_W(SIZE_W), .QID_W(QID_W)) m_if ();

   c2h_rr_arbiter #(
      .NUM_PORTS(NP), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .QID_W(QID_W), .CNT_W(CNT_W)
   ) dut (
      .axis_aclk(clk),
      .axis_areset(rst),
      .s_axis(s_if),
      .m_axis_c2h(m_if),
      .grant_idx(grant_idx),
      .busy(busy),
      .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] tvalid;
      logic [3:0] tlast;
      logic       mready;
      logic       exp_tvalid;
      logic       exp_tlast;
      logic [3:0] exp_tready;
      int         exp_src;
      logic       exp_busy;
      logic [1:0] exp_grant;
      logic [3:0] exp_cnt;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk_vec(input logic [3:0] tv, input logic [3:0] tl, input logic mr,
                                   input logic et, input logic el, input logic [3:0] er,
                                   input int src, input logic eb, input logic [1:0] eg,
                                   input logic [3:0] ec);
      vec_t v;
      v.tvalid = tv; v.tlast = tl; v.mready = mr;
      v.exp_tvalid = et; v.exp_tlast = el; v.exp_tready = er;
      v.exp_src = src; v.exp_busy = eb; v.exp_grant = eg; v.exp_cnt = ec;
      return v;
   endfunction

   function automatic logic [DATA_W-1:0] port_data(input int src);
      if (src < 0) return '0;
      return {16{32'hC0DE_0000 | 32'(src)}};
   endfunction

   function automatic logic [SIZE_W-1:0] port_size(input int src);
      if (src < 0) return '0;
      return SIZE_W'(64 * (src + 1));
   endfunction

   function automatic logic [QID_W-1:0] port_qid(input int src);
      if (src < 0) return '0;
      return QID_W'(11'h010 + src);
   endfunction

   task automatic set_port_defaults();
      for (int i = 0; i < NP; i++) begin
         s_if.tdata[i*DATA_W +: DATA_W]      = port_data(i);
         s_if.tuser_size[i*SIZE_W +: SIZE_W] = port_size(i);
         s_if.tuser_qid[i*QID_W +: QID_W]    = port_qid(i);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] tv, input logic [3:0] tl, input logic mr);
      s_if.tvalid = tv;
      s_if.tlast  = tl;
      m_if.tready = mr;
   endtask

   task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_bus(input string tag, input logic et, input logic el,
                            input logic [3:0] er, input int src);
      checkOutput({tag, ".tvalid"}, DATA_W'(m_if.tvalid), DATA_W'(et));
      checkOutput({tag, ".tlast"},  DATA_W'(m_if.tlast),  DATA_W'(el));
      checkOutput({tag, ".tready"}, DATA_W'(s_if.tready), DATA_W'(er));
      checkOutput({tag, ".tdata"},  m_if.tdata,           port_data(src));
      checkOutput({tag, ".size"},   DATA_W'(m_if.tuser_size), DATA_W'(port_size(src)));
      checkOutput({tag, ".qid"},    DATA_W'(m_if.tuser_qid),  DATA_W'(port_qid(src)));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns one time unit after an edge with reset released and the DUT in IDLE.
   task automatic do_reset();
      rst = 1'b1;
      applyStimulus(4'h0, 4'h0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int bp_cycles;
      int beat;
      logic acc;

      set_port_defaults();
      applyStimulus(4'h0, 4'h0, 1'b0);
      #2;
      check_bus("reset", 1'b0, 1'b0, 4'h0, -1);
      checkOutput("reset.busy",  DATA_W'(busy),      '0);
      checkOutput("reset.grant", DATA_W'(grant_idx), '0);
      checkOutput("reset.cnt",   DATA_W'(pkt_count), '0);

      vecs[0]  = mk_vec(4'hF, 4'h0, 1, 0, 0, 4'h0, -1, 0, 2'd0, 4'd0);
      vecs[1]  = mk_vec(4'hF, 4'h0, 1, 1, 0, 4'h1,  0, 1, 2'd0, 4'd0);
      vecs[2]  = mk_vec(4'hF, 4'h1, 1, 1, 1, 4'h1,  0, 1, 2'd0, 4'd0);
      vecs[3]  = mk_vec(4'hF, 4'h0, 1, 0, 0, 4'h0, -1, 0, 2'd0, 4'd1);
      vecs[4]  = mk_vec(4'hF, 4'h0, 1, 1, 0, 4'h2,  1, 1, 2'd1, 4'd1);
      vecs[5]  = mk_vec(4'hF, 4'h2, 1, 1, 1, 4'h2,  1, 1, 2'd1, 4'd1);
      vecs[6]  = mk_vec(4'hF, 4'h0, 1, 0, 0, 4'h0, -1, 0, 2'd1, 4'd2);
      vecs[7]  = mk_vec(4'hF, 4'h0, 1, 1, 0, 4'h4,  2, 1, 2'd2, 4'd2);
      vecs[8]  = mk_vec(4'hF, 4'h4, 1, 1, 1, 4'h4,  2, 1, 2'd2, 4'd2);
      vecs[9]  = mk_vec(4'hF, 4'h0, 1, 0, 0, 4'h0, -1, 0, 2'd2, 4'd3);
      vecs[10] = mk_vec(4'hF, 4'h0, 1, 1, 0, 4'h8,  3, 1, 2'd3, 4'd3);
      vecs[11] = mk_vec(4'hF, 4'h8, 1, 1, 1, 4'h8,  3, 1, 2'd3, 4'd3);
      vecs[12] = mk_vec(4'hF, 4'h0, 1, 0, 0, 4'h0, -1, 0, 2'd3, 4'd4);
      vecs[13] = mk_vec(4'hF, 4'h0, 1, 1, 0, 4'h1,  0, 1, 2'd0, 4'd4);
      vecs[14] = mk_vec(4'hF, 4'h1, 1, 1, 1, 4'h1,  0, 1, 2'd0, 4'd4);
      vecs[15] = mk_vec(4'hF, 4'h0, 1, 0, 0, 4'h0, -1, 0, 2'd0, 4'd5);

      // Single 1-beat packet from port 2 with its own size/qid/data.
      do_reset();
      s_if.tdata[2*DATA_W +: DATA_W]      = {16{32'h1234_5678}};
      s_if.tuser_size[2*SIZE_W +: SIZE_W] = 16'd128;
      s_if.tuser_qid[2*QID_W +: QID_W]    = 11'h0fa;
      applyStimulus(4'b0100, 4'b0100, 1'b1);
      #1;
      checkOutput("single.idle_tvalid", DATA_W'(m_if.tvalid), '0);
      tick();
      applyStimulus(4'b0100, 4'b0100, 1'b1);
      #1;
      checkOutput("single.tvalid", DATA_W'(m_if.tvalid), DATA_W'(1));
      checkOutput("single.tlast",  DATA_W'(m_if.tlast),  DATA_W'(1));
      checkOutput("single.qid",    DATA_W'(m_if.tuser_qid),  DATA_W'(11'h0fa));
      checkOutput("single.size",   DATA_W'(m_if.tuser_size), DATA_W'(128));
      checkOutput("single.tdata",  m_if.tdata, {16{32'h1234_5678}});
      checkOutput("single.tready", DATA_W'(s_if.tready), DATA_W'(4'b0100));
      tick();
      applyStimulus(4'h0, 4'h0, 1'b1);
      #1;
      checkOutput("single.cnt",   DATA_W'(pkt_count), DATA_W'(1));
      checkOutput("single.grant", DATA_W'(grant_idx), DATA_W'(2));
      checkOutput("single.busy",  DATA_W'(busy),      '0);
      set_port_defaults();

      // All ports continuously requesting 2-beat packets.
      do_reset();
      for (int v = 0; v < 16; v++) begin
         applyStimulus(vecs[v].tvalid, vecs[v].tlast, vecs[v].mready);
         #1;
         check_bus($sformatf("rr[%0d]", v), vecs[v].exp_tvalid, vecs[v].exp_tlast,
                   vecs[v].exp_tready, vecs[v].exp_src);
         checkOutput($sformatf("rr[%0d].busy", v),  DATA_W'(busy),      DATA_W'(vecs[v].exp_busy));
         checkOutput($sformatf("rr[%0d].grant", v), DATA_W'(grant_idx), DATA_W'(vecs[v].exp_grant));
         checkOutput($sformatf("rr[%0d].cnt", v),   DATA_W'(pkt_count), DATA_W'(vecs[v].exp_cnt));
         tick();
      end

      // Port 1 requests mid-packet; it must wait for port 0's tlast plus one IDLE cycle.
      do_reset();
      applyStimulus(4'b0001, 4'b0000, 1'b1); #1;
      checkOutput("nointl.c0_tvalid", DATA_W'(m_if.tvalid), '0);
      tick();
      applyStimulus(4'b0001, 4'b0000, 1'b1); #1;
      check_bus("nointl.c1", 1'b1, 1'b0, 4'b0001, 0);
      tick();
      applyStimulus(4'b0011, 4'b0000, 1'b1); #1;
      check_bus("nointl.c2", 1'b1, 1'b0, 4'b0001, 0);
      tick();
      applyStimulus(4'b0011, 4'b0001, 1'b1); #1;
      check_bus("nointl.c3", 1'b1, 1'b1, 4'b0001, 0);
      tick();
      applyStimulus(4'b0010, 4'b0010, 1'b1); #1;
      check_bus("nointl.c4", 1'b0, 1'b0, 4'b0000, -1);
      checkOutput("nointl.c4_busy", DATA_W'(busy), '0);
      tick();
      applyStimulus(4'b0010, 4'b0010, 1'b1); #1;
      check_bus("nointl.c5", 1'b1, 1'b1, 4'b0010, 1);
      checkOutput("nointl.c5_grant", DATA_W'(grant_idx), DATA_W'(1));
      tick();
      applyStimulus(4'h0, 4'h0, 1'b1); #1;
      checkOutput("nointl.cnt", DATA_W'(pkt_count), DATA_W'(2));

      // Reset during beat 2 of a 3-beat packet; last owner was port 1, so without reset port 3 would win next.
      applyStimulus(4'b0001, 4'b0000, 1'b1);
      tick();
      applyStimulus(4'b0001, 4'b0000, 1'b1); #1;
      checkOutput("midrst.b1_grant", DATA_W'(grant_idx), '0);
      tick();
      applyStimulus(4'b0001, 4'b0000, 1'b1); #1;
      checkOutput("midrst.b2_tvalid", DATA_W'(m_if.tvalid), DATA_W'(1));
      rst = 1'b1;
      #1;
      check_bus("midrst.async", 1'b0, 1'b0, 4'b0000, -1);
      checkOutput("midrst.busy", DATA_W'(busy),      '0);
      checkOutput("midrst.cnt",  DATA_W'(pkt_count), '0);
      tick();
      rst = 1'b0;
      applyStimulus(4'b1001, 4'b1001, 1'b1); #1;
      checkOutput("midrst.idle_tvalid", DATA_W'(m_if.tvalid), '0);
      tick();
      applyStimulus(4'b1001, 4'b1001, 1'b1); #1;
      checkOutput("midrst.grant", DATA_W'(grant_idx), '0);
      checkOutput("midrst.qid",   DATA_W'(m_if.tuser_qid), DATA_W'(port_qid(0)));
      checkOutput("midrst.cnt0",  DATA_W'(pkt_count), '0);

      // Backpressure on a 4-beat packet from port 3: ready alternates, beats advance only on ready.
      do_reset();
      beat = 0;
      bp_cycles = 0;
      s_if.tdata[3*DATA_W +: DATA_W] = {16{32'hBEA7_0000}};
      applyStimulus(4'b1000, 4'b0000, 1'b1); #1;
      checkOutput("bp.idle_tvalid", DATA_W'(m_if.tvalid), '0);
      tick();
      for (int bc = 1; bc <= 20; bc++) begin
         acc = (bc % 2 == 0);
         s_if.tdata[3*DATA_W +: DATA_W] = {16{32'hBEA7_0000 + 32'(beat)}};
         applyStimulus(4'b1000, (beat == 3) ? 4'b1000 : 4'b0000, acc);
         #1;
         checkOutput($sformatf("bp[%0d].tvalid", bc), DATA_W'(m_if.tvalid), DATA_W'(1));
         checkOutput($sformatf("bp[%0d].tdata", bc), m_if.tdata, {16{32'hBEA7_0000 + 32'(beat)}});
         checkOutput($sformatf("bp[%0d].tready", bc), DATA_W'(s_if.tready),
                     DATA_W'({acc, 3'b000}));
         tick();
         bp_cycles = bc;
         if (acc) beat++;
         if (beat == 4) break;
      end
      checkOutput("bp.done", DATA_W'(beat), DATA_W'(4));
      checkOutput("bp.busy_cycles", DATA_W'(bp_cycles), DATA_W'(8));
      applyStimulus(4'h0, 4'h0, 1'b1); #1;
      checkOutput("bp.busy", DATA_W'(busy),      '0);
      checkOutput("bp.cnt",  DATA_W'(pkt_count), DATA_W'(1));
      set_port_defaults();

      // 17 back-to-back single-beat packets wrap the 4-bit counter to 1.
      do_reset();
      for (int p = 1; p <= 17; p++) begin
         applyStimulus(4'b0001, 4'b0001, 1'b1);
         tick();
         tick();
         if (p == 15) checkOutput("wrap.cnt15", DATA_W'(pkt_count), DATA_W'(15));
      end
      applyStimulus(4'h0, 4'h0, 1'b1); #1;
      checkOutput("wrap.cnt", DATA_W'(pkt_count), DATA_W'(1));
      checkOutput("wrap.busy", DATA_W'(busy), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end
endmodule
